// File: rtl/tmds_decoder.sv
// tmds_decoder: receive-side TMDS lane decoder with control-token word alignment and lock tracking
// Ports: clk_pixel_in/rst_n_in clock and async active-low reset; word_in/word_valid_in raw
// deserialized words (bit 0 first); data_out/ctrl_out/de_out decoded symbol; valid_out output
// strobe while locked; locked_out alignment lock; offset_out current bit-slip offset 0..9.
// Define TMDS_DECODER_STATS_EN to add saturating slip_count_out/loss_count_out statistics ports.
module tmds_decoder #(
    parameter int SEARCH_WINDOW = 4096,
    parameter int LOSS_WINDOW   = 4096,
    parameter int MIN_CTRL_RUN  = 8
) (
    input  logic       clk_pixel_in,
    input  logic       rst_n_in,
    input  logic [9:0] word_in,
    input  logic       word_valid_in,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de_out,
    output logic       valid_out,
    output logic       locked_out,
    output logic [3:0] offset_out
`ifdef TMDS_DECODER_STATS_EN
    ,
    output logic [7:0] slip_count_out,
    output logic [7:0] loss_count_out
`endif
);
    localparam int SW = SEARCH_WINDOW > 1 ? $clog2(SEARCH_WINDOW) : 1;
    localparam int LW = LOSS_WINDOW > 1 ? $clog2(LOSS_WINDOW) : 1;
    localparam int MW = SW > LW ? SW : LW;
    localparam int RW = MIN_CTRL_RUN > 1 ? $clog2(MIN_CTRL_RUN) : 1;
    localparam logic [MW-1:0] SEARCH_LAST = MW'(SEARCH_WINDOW - 1);
    localparam logic [MW-1:0] LOSS_LAST = MW'(LOSS_WINDOW - 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(MIN_CTRL_RUN - 1);
    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t          state, nxt;
    logic [9:0]      cur, aligned, sel;
    logic [19:0]     win;
    logic [MW-1:0]   miss, miss_nxt;
    logic [RW-1:0]   run, run_nxt;
    logic [3:0]      offset, off_nxt;
    logic            is_tok, slip, loss, lock_nxt;
    logic [1:0]      code;
    logic [7:0]      q, d;

    // Offset k takes the symbol that begins k bits before the newly arrived word.
    assign win = {word_in, cur};
    assign sel = 10'(win >> (4'd10 - offset));

    assign is_tok = aligned == T00 || aligned == T01 || aligned == T10 || aligned == T11;
    assign code = {aligned == T10 || aligned == T11, aligned == T01 || aligned == T11};

    // Undo the conditional inversion, then the XOR/XNOR transition chain.
    assign q = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    assign d = {q[7:1] ^ q[6:0] ^ {7{~aligned[8]}}, q[0]};

    always_comb begin
        nxt = state;
        miss_nxt = miss;
        run_nxt = run;
        off_nxt = offset;
        slip = 1'b0;
        loss = 1'b0;
        case (state)
            SEARCH:
                if (is_tok) begin
                    nxt = VERIFY;
                    run_nxt = RW'(1);
                end else if (miss == SEARCH_LAST) begin
                    miss_nxt = '0;
                    slip = 1'b1;
                    off_nxt = offset == 4'd9 ? 4'd0 : offset + 4'd1;
                end else begin
                    miss_nxt = miss + 1'b1;
                end
            VERIFY:
                if (!is_tok) begin
                    nxt = SEARCH;
                    run_nxt = '0;
                end else if (run == RUN_LAST) begin
                    nxt = LOCKED;
                    miss_nxt = '0;
                    run_nxt = '0;
                end else begin
                    run_nxt = run + 1'b1;
                end
            LOCKED:
                if (is_tok) begin
                    miss_nxt = '0;
                end else if (miss == LOSS_LAST) begin
                    nxt = SEARCH;
                    miss_nxt = '0;
                    loss = 1'b1;
                end else begin
                    miss_nxt = miss + 1'b1;
                end
            default: nxt = SEARCH;
        endcase
    end

    always_comb begin
        lock_nxt = nxt == LOCKED;
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= SEARCH;
            cur <= '0;
            aligned <= '0;
            miss <= '0;
            run <= '0;
            offset <= '0;
        end else if (word_valid_in) begin
            state <= nxt;
            cur <= word_in;
            aligned <= sel;
            miss <= miss_nxt;
            run <= run_nxt;
            offset <= off_nxt;
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_out <= '0;
            ctrl_out <= '0;
            de_out <= 1'b0;
            valid_out <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            valid_out <= word_valid_in && lock_nxt;
            if (word_valid_in) begin
                locked_out <= lock_nxt;
                de_out <= !is_tok;
                if (is_tok) ctrl_out <= code;
                else data_out <= d;
            end
        end
    end

    assign offset_out = offset;

`ifdef TMDS_DECODER_STATS_EN
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            slip_count_out <= '0;
            loss_count_out <= '0;
        end else if (word_valid_in) begin
            if (slip && slip_count_out != 8'hFF) slip_count_out <= slip_count_out + 8'd1;
            if (loss && loss_count_out != 8'hFF) loss_count_out <= loss_count_out + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: directed vector bench for tmds_decoder
module tb_tmds_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] word = '0;
    logic       valid = 1'b0;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de, vout, locked;
    logic [3:0] offset;
`ifdef TMDS_DECODER_STATS_EN
    logic [7:0] slips, losses;
`endif
    int total = 0;
    int bad = 0;
    logic [9:0] psym = 10'h354;

    localparam logic [9:0] TOK = 10'h354;

    tmds_decoder #(.SEARCH_WINDOW(16), .LOSS_WINDOW(32), .MIN_CTRL_RUN(8)) dut (
        .clk_pixel_in(clk),
        .rst_n_in(rst_n),
        .word_in(word),
        .word_valid_in(valid),
        .data_out(data),
        .ctrl_out(ctrl),
        .de_out(de),
        .valid_out(vout),
        .locked_out(locked),
        .offset_out(offset)
`ifdef TMDS_DECODER_STATS_EN
        ,
        .slip_count_out(slips),
        .loss_count_out(losses)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] sym;
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step(input logic [9:0] w, input logic v);
        word = w;
        valid = v;
        @(posedge clk);
        #1;
    endtask

    // Sends a symbol on a stream delayed by 3 bits: the symbol straddles two words.
    task automatic send_sym(input logic [9:0] s);
        step({s[2:0], psym[9:3]}, 1'b1);
        psym = s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        word = '0;
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        psym = TOK;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{10'h100, 1'b1, 8'h00, 2'b00};
        tbl[1]  = '{10'h200, 1'b1, 8'hFF, 2'b00};
        tbl[2]  = '{10'h0AB, 1'b0, 8'hFF, 2'b01};
        tbl[3]  = '{10'h154, 1'b0, 8'hFF, 2'b10};
        tbl[4]  = '{10'h2AB, 1'b0, 8'hFF, 2'b11};
        tbl[5]  = '{10'h1FF, 1'b1, 8'h01, 2'b11};
        tbl[6]  = '{10'h000, 1'b1, 8'hFE, 2'b11};
        tbl[7]  = '{10'h354, 1'b0, 8'hFE, 2'b00};
        tbl[8]  = '{10'h2F0, 1'b1, 8'hEF, 2'b00};
        tbl[9]  = '{10'h155, 1'b1, 8'hFF, 2'b00};
        tbl[10] = '{10'h1A5, 1'b1, 8'hEF, 2'b00};
        tbl[11] = '{10'h0AB, 1'b0, 8'hEF, 2'b01};

        do_reset();
        check("reset_outs", {data, ctrl, de, vout, locked, offset}, 0);

        // No tokens at all: offset slips every 16 words and wraps 9 -> 0.
        for (int s = 1; s <= 160; s++) begin
            step(10'h000, 1'b1);
            if (s == 15) check("slip_off15", offset, 0);
            if (s == 16) check("slip_off16", offset, 1);
            if (s == 144) check("slip_off144", offset, 9);
            if (s == 160) check("slip_wrap", offset, 0);
        end
        check("search_unlocked", {vout, locked}, 0);
`ifdef TMDS_DECODER_STATS_EN
        check("stat_slips10", slips, 10);
`endif

        // Aligned lock, then table of data/control symbols.
        for (int k = 0; k < 8; k++) step(TOK, 1'b1);
        check("pre_lock", locked, 0);
        for (int i = 0; i <= 12; i++) begin
            step(i < 12 ? tbl[i].sym : TOK, 1'b1);
            if (i == 0) check("lock_after_8", {vout, locked, de, ctrl}, {3'b110, 2'b00});
            else check($sformatf("vec%0d", i - 1), {vout, locked, de, ctrl, data},
                       {1'b1, 1'b1, tbl[i-1].de, tbl[i-1].ctrl, tbl[i-1].data});
        end

        // Loss window counted only on valid words; idle cycles hold and give valid_out=0.
        for (int k = 1; k <= 32; k++) begin
            step(10'h100, 1'b1);
            check($sformatf("loss_v%0d", k), {vout, locked}, 2'b11);
            step(10'h155, 1'b0);
            check($sformatf("loss_idle%0d", k), {vout, locked}, 2'b01);
        end
        step(10'h100, 1'b1);
        check("loss_drop", {vout, locked, offset}, 0);

        // Relock and lose again with an uninterrupted data run.
        for (int k = 0; k < 10; k++) step(TOK, 1'b1);
        check("relock", locked, 1);
        for (int k = 1; k <= 33; k++) begin
            step(10'h100, 1'b1);
            if (k == 32) check("loss2_hold", locked, 1);
            if (k == 33) check("loss2_drop", locked, 0);
        end
`ifdef TMDS_DECODER_STATS_EN
        check("stat_slips", slips, 10);
        check("stat_losses", losses, 2);
`endif

        // Asynchronous reset while locked.
        do_reset();
        for (int k = 0; k < 10; k++) step(TOK, 1'b1);
        check("lock_before_rst", {vout, locked, de, data}, {3'b110, 8'hFE});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {data, ctrl, de, vout, locked, offset}, 0);
`ifdef TMDS_DECODER_STATS_EN
        check("async_rst_stats", {slips, losses}, 0);
`endif

        // A data word during VERIFY restarts the token run.
        do_reset();
        for (int s = 1; s <= 15; s++) begin
            step(s == 6 ? 10'h100 : TOK, 1'b1);
            if (s == 7) check("verify_fallback", {locked, offset}, 0);
            if (s == 14) check("verify_not_yet", locked, 0);
            if (s == 15) check("verify_relock", {locked, offset}, 5'b10000);
        end

        // Stream delayed by 3 bits: offset walks 0..3, then locks and decodes.
        do_reset();
        for (int s = 1; s <= 57; s++) begin
            send_sym(TOK);
            if (s == 15) check("rot_off15", offset, 0);
            if (s == 16) check("rot_off16", offset, 1);
            if (s == 32) check("rot_off32", offset, 2);
            if (s == 48) check("rot_off48", offset, 3);
            if (s == 56) check("rot_unlocked56", locked, 0);
            if (s == 57) check("rot_locked57", {locked, offset}, 5'b10011);
        end
        send_sym(10'h100);
        send_sym(10'h200);
        send_sym(TOK);
        check("rot_data00", {vout, locked, de, data}, {3'b111, 8'h00});
        send_sym(TOK);
        check("rot_dataFF", {vout, locked, de, data}, {3'b111, 8'hFF});
`ifdef TMDS_DECODER_STATS_EN
        check("rot_slips", slips, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
